// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns pc and ir, issues one memory read per fetch_req,
// and substitutes a NOOP with a sticky fault when memory does not answer in time.
//
// state  | meaning
// S_IDLE | waiting for fetch_req; pc_ld loads pc directly
// S_REQ  | imem_rd asserted, waiting for imem_rdy or timeout
// S_DONE | ir_valid pulse; pc advances or takes the pending target
module fetch_unit #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_f,
   input  logic        fetch_req,
   input  logic        pc_ld,
   input  logic [15:0] pc_target,
   input  logic        imem_rdy,
   input  logic [31:0] imem_data,
   output logic        imem_rd,
   output logic [15:0] imem_addr,
   output logic [31:0] ir,
   output logic [3:0]  opcode,
   output logic [3:0]  mm,
   output logic [15:0] pc,
   output logic        ir_valid,
   output logic        busy,
   output logic        fault
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] TO_FULL = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   pc_q, pc_d;
   logic [15:0]   pend_q, pend_d;
   logic          pend_vld_q, pend_vld_d;
   logic [31:0]   ir_q, ir_d;
   logic          fault_q, fault_d;
   logic          tmo_q, tmo_d;

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         pc_q       <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         ir_q       <= '0;
         fault_q    <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pc_q       <= pc_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         ir_q       <= ir_d;
         fault_q    <= fault_d;
         tmo_q      <= tmo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_d       = pc_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      ir_d       = ir_q;
      fault_d    = fault_q;
      tmo_d      = tmo_q;
      imem_rd    = 1'b0;
      ir_valid   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pc_ld) pc_d = pc_target;
            if (fetch_req) begin
               state_d = S_REQ;
               cnt_d   = '0;
               tmo_d   = 1'b0;
            end
         end
         S_REQ: begin
            imem_rd = 1'b1;
            if (pc_ld) begin
               pend_d     = pc_target;
               pend_vld_d = 1'b1;
            end
            if (imem_rdy) begin
               ir_d    = imem_data;
               state_d = S_DONE;
            end else if (cnt_q == TO_LAST) begin
               ir_d    = 32'h0;
               fault_d = 1'b1;
               tmo_d   = 1'b1;
               state_d = S_DONE;
            end else if (cnt_q != TO_FULL) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            ir_valid   = 1'b1;
            state_d    = S_IDLE;
            pend_d     = '0;
            pend_vld_d = 1'b0;
            // A pc_ld arriving in DONE is the most recent target, so it beats the pending one
            if (pc_ld)           pc_d = pc_target;
            else if (pend_vld_q) pc_d = pend_q;
            else if (!tmo_q)     pc_d = pc_q + 16'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign opcode    = ir_q[31:28];
   assign mm        = ir_q[27:24];
   assign busy      = (state_q != S_IDLE);
   assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of fetch transactions plus
// hand-written sequences for timeout, pending branch target and reset mid-fetch.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_f;
   logic        fetch_req, pc_ld, imem_rdy;
   logic [15:0] pc_target;
   logic [31:0] imem_data;
   logic        imem_rd, ir_valid, busy, fault;
   logic [15:0] imem_addr, pc;
   logic [31:0] ir;
   logic [3:0]  opcode, mm;

   int n_cmp = 0;
   int n_err = 0;

   fetch_unit #(.TIMEOUT(15)) dut (
      .clk(clk), .rst_f(rst_f), .fetch_req(fetch_req), .pc_ld(pc_ld),
      .pc_target(pc_target), .imem_rdy(imem_rdy), .imem_data(imem_data),
      .imem_rd(imem_rd), .imem_addr(imem_addr), .ir(ir), .opcode(opcode),
      .mm(mm), .pc(pc), .ir_valid(ir_valid), .busy(busy), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int          ld_mode;   // 0 none, 1 pc_ld in IDLE before fetch, 2 pc_ld with fetch_req
      logic [15:0] target;
      int          delay;     // REQ cycles without imem_rdy
      logic [31:0] data;
      logic [15:0] exp_addr;
      logic [31:0] exp_ir;
      logic [15:0] exp_pc;
      logic        exp_fault;
   } vec_t;

   task automatic do_fetch(input vec_t v);
      int rd_cnt;
      if (v.ld_mode == 1) begin
         pc_ld = 1'b1; pc_target = v.target;
         tick();
         pc_ld = 1'b0;
         check("idle_pc_ld", {16'h0, pc}, {16'h0, v.target});
      end
      fetch_req = 1'b1;
      pc_ld     = (v.ld_mode == 2);
      pc_target = v.target;
      imem_rdy  = 1'b0;
      tick();
      fetch_req = 1'b0;
      pc_ld     = 1'b0;
      check("req_rd", {31'h0, imem_rd}, 32'h1);
      check("req_addr", {16'h0, imem_addr}, {16'h0, v.exp_addr});
      rd_cnt = 1;
      for (int i = 0; i < v.delay; i++) begin
         tick();
         if (imem_rd && imem_addr == v.exp_addr && !ir_valid) rd_cnt++;
      end
      check("rd_cycles", rd_cnt, v.delay + 1);
      imem_rdy  = 1'b1;
      imem_data = v.data;
      tick();
      imem_rdy = 1'b0;
      check("done_valid", {31'h0, ir_valid}, 32'h1);
      check("done_ir", ir, v.exp_ir);
      check("done_opcode", {28'h0, opcode}, {28'h0, v.exp_ir[31:28]});
      check("done_mm", {28'h0, mm}, {28'h0, v.exp_ir[27:24]});
      check("done_rd", {31'h0, imem_rd}, 32'h0);
      tick();
      check("after_valid", {31'h0, ir_valid}, 32'h0);
      check("after_busy", {31'h0, busy}, 32'h0);
      check("after_pc", {16'h0, pc}, {16'h0, v.exp_pc});
      check("after_fault", {31'h0, fault}, {31'h0, v.exp_fault});
   endtask

   vec_t vecs[4];

   initial begin
      int n;
      vec_t v;
      vecs[0] = '{0, 16'h0000, 0, 32'h1234_5678, 16'h0000, 32'h1234_5678, 16'h0001, 1'b0};
      vecs[1] = '{0, 16'h0000, 3, 32'hA5A5_0001, 16'h0001, 32'hA5A5_0001, 16'h0002, 1'b0};
      vecs[2] = '{1, 16'hFFFF, 1, 32'hDEAD_BEEF, 16'hFFFF, 32'hDEAD_BEEF, 16'h0000, 1'b0};
      vecs[3] = '{2, 16'h0100, 0, 32'h0F00_0000, 16'h0100, 32'h0F00_0000, 16'h0101, 1'b0};

      rst_f = 1'b0; fetch_req = 1'b0; pc_ld = 1'b0; pc_target = '0;
      imem_rdy = 1'b0; imem_data = '0;
      tick(); tick();
      check("rst_pc", {16'h0, pc}, 32'h0);
      check("rst_ir", ir, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_rd", {31'h0, imem_rd}, 32'h0);
      check("rst_fault", {31'h0, fault}, 32'h0);
      check("rst_valid", {31'h0, ir_valid}, 32'h0);
      rst_f = 1'b1;
      tick();

      for (int i = 0; i < 4; i++) do_fetch(vecs[i]);

      // Timeout: memory never answers; 15 REQ cycles then NOOP + fault, pc held
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      n = 0;
      while (imem_rd && n < 40) begin
         n++;
         tick();
      end
      check("tmo_req_cycles", n, 15);
      check("tmo_valid", {31'h0, ir_valid}, 32'h1);
      check("tmo_ir", ir, 32'h0);
      check("tmo_fault", {31'h0, fault}, 32'h1);
      tick();
      check("tmo_pc_held", {16'h0, pc}, 32'h0101);
      v = '{0, 16'h0000, 0, 32'h2300_0007, 16'h0101, 32'h2300_0007, 16'h0102, 1'b1};
      do_fetch(v);

      // pc_ld twice during REQ (last wins) plus an ignored fetch_req while busy
      fetch_req = 1'b1;
      tick();
      pc_ld = 1'b1; pc_target = 16'h0030;
      tick();
      pc_target = 16'h0040; fetch_req = 1'b1;
      tick();
      pc_ld = 1'b0; fetch_req = 1'b0;
      check("pend_addr_stable", {16'h0, imem_addr}, 32'h0102);
      imem_rdy = 1'b1; imem_data = 32'h4400_0000;
      tick();
      imem_rdy = 1'b0;
      check("pend_valid", {31'h0, ir_valid}, 32'h1);
      tick();
      check("pend_pc", {16'h0, pc}, 32'h0040);
      tick();
      check("no_queued_fetch", {31'h0, busy}, 32'h0);

      // Reset mid-REQ, then a late imem_rdy must be ignored
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      #2 rst_f = 1'b0;
      #1;
      check("rst_mid_busy", {31'h0, busy}, 32'h0);
      check("rst_mid_rd", {31'h0, imem_rd}, 32'h0);
      rst_f = 1'b1;
      imem_rdy = 1'b1; imem_data = 32'hCAFE_F00D;
      tick();
      imem_rdy = 1'b0;
      check("late_rdy_ir", ir, 32'h0);
      check("late_rdy_valid", {31'h0, ir_valid}, 32'h0);
      check("late_rdy_busy", {31'h0, busy}, 32'h0);
      check("late_rdy_fault", {31'h0, fault}, 32'h0);
      check("late_rdy_pc", {16'h0, pc}, 32'h0);
      v = '{0, 16'h0000, 0, 32'h5600_0001, 16'h0000, 32'h5600_0001, 16'h0001, 1'b0};
      do_fetch(v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
